// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared constants and types for the UART camera-command receiver:
//   - SYNC byte and opcode values of the 5-byte command packet
//   - byte-level receiver FSM states and packet-level FSM states
//   - checksum helper (XOR of OPCODE, ADDR and DATA)
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] OPC_WRITE = 8'h01;
    localparam logic [7:0] OPC_PIC   = 8'h02;
    localparam logic [7:0] OPC_HDR   = 8'h03;

    typedef enum logic [1:0] {
        BYTE_IDLE  = 2'd0,
        BYTE_START = 2'd1,
        BYTE_DATA  = 2'd2,
        BYTE_STOP  = 2'd3
    } byte_state_e;

    typedef enum logic [2:0] {
        PKT_WAIT_SYNC = 3'd0,
        PKT_OPC       = 3'd1,
        PKT_ADDR      = 3'd2,
        PKT_DATA      = 3'd3,
        PKT_CHK       = 3'd4
    } pkt_state_e;

    // Packet checksum: plain XOR of the three payload bytes.
    function automatic logic [7:0] pkt_checksum(input logic [7:0] opc,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
        return opc ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART byte receiver with 16x oversampling.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   rx         : raw asynchronous serial line (idle high, LSB first)
//   rx_byte    : last received byte, valid while byte_valid is high
//   byte_valid : one-cycle pulse, stop bit sampled high
//   frame_err  : one-cycle pulse, stop bit sampled low (byte discarded)
// Parameter DIV: clk cycles per oversample tick (clamped to at least 1).
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned DIV_C    = (DIV < 1) ? 1 : DIV;
    localparam logic [31:0] DIV_LAST = 32'(DIV_C - 1);

    logic        rx_meta_q, rx_sync_q;
    byte_state_e state_q, state_d;
    logic [31:0] div_cnt_q, div_cnt_d;
    logic [3:0]  tick_cnt_q, tick_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        brk_q, brk_d;
    logic        tick_s;

    assign tick_s     = (div_cnt_q == DIV_LAST);
    assign rx_byte    = data_q;
    assign byte_valid = valid_q;
    assign frame_err  = ferr_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state logic for the tick divider and the byte FSM.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        brk_d      = brk_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        if (tick_s) begin
            div_cnt_d = 32'd0;
        end else begin
            div_cnt_d = div_cnt_q + 32'd1;
        end

        case (state_q)
            BYTE_IDLE: begin
                if (!rx_sync_q) begin
                    // Re-phase the divider to the start edge.
                    state_d    = BYTE_START;
                    div_cnt_d  = 32'd0;
                    tick_cnt_d = 4'd0;
                end else begin
                    state_d = BYTE_IDLE;
                end
            end
            BYTE_START: begin
                if (tick_s && (tick_cnt_q == 4'd7)) begin
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 3'd0;
                    // Line back high at mid start bit: glitch, drop silently.
                    if (!rx_sync_q) begin
                        state_d = BYTE_DATA;
                    end else begin
                        state_d = BYTE_IDLE;
                    end
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            BYTE_DATA: begin
                if (tick_s && (tick_cnt_q == 4'd15)) begin
                    tick_cnt_d = 4'd0;
                    shift_d    = {rx_sync_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = BYTE_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            BYTE_STOP: begin
                if (brk_q) begin
                    // After a framing error, wait for the line to go idle.
                    if (rx_sync_q) begin
                        brk_d   = 1'b0;
                        state_d = BYTE_IDLE;
                    end else begin
                        state_d = BYTE_STOP;
                    end
                end else if (tick_s && (tick_cnt_q == 4'd15)) begin
                    tick_cnt_d = 4'd0;
                    if (rx_sync_q) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = BYTE_IDLE;
                    end else begin
                        ferr_d = 1'b1;
                        brk_d  = 1'b1;
                    end
                end else if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            default: begin
                state_d = BYTE_IDLE;
            end
        endcase
    end

    // Byte FSM and divider registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BYTE_IDLE;
            div_cnt_q  <= 32'd0;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// uart_cmd_rx
// UART command receiver for camera control. Decodes 5-byte packets
// A5 / OPCODE / ADDR / DATA / CHK and produces SCCB write, capture and
// HDR-mode controls.
//   clk        : system clock          rst_n     : async active-low reset
//   RX         : UART line (8N1)       conf_addr : register address of last write
//   conf_data  : register data of last write
//   sccb_start : 1-cycle pulse, start SCCB write
//   take_pic   : 1-cycle pulse, capture request
//   hdr_en     : HDR mode level
//   cmd_err    : 1-cycle pulse on framing/checksum/opcode/timeout error
//   busy_led   : high while a packet is in progress
// Build option: define UART_CMD_RX_CHECKSUM_EN to verify the CHK byte;
// otherwise CHK is received but not checked.
// -----------------------------------------------------------------------------
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned TIMEOUT_CYC = 2500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] conf_addr,
    output logic [7:0] conf_data,
    output logic       sccb_start,
    output logic       take_pic,
    output logic       hdr_en,
    output logic       cmd_err,
    output logic       busy_led
);

    localparam int unsigned DIV_RAW = CLK_HZ / (16 * BAUD);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TO_C    = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
    localparam logic [31:0] TO_LAST = 32'(TO_C - 1);

    logic [7:0] rx_byte_s;
    logic       byte_valid_s;
    logic       frame_err_s;
    logic       chk_ok_s;

    pkt_state_e pkt_q, pkt_d;
    logic [7:0] opc_q, opc_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] dat_q, dat_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0] conf_addr_q, conf_addr_d;
    logic [7:0] conf_data_q, conf_data_d;
    logic       hdr_q, hdr_d;
    logic       sccb_q, sccb_d;
    logic       pic_q, pic_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    uart_rx_byte #(
        .DIV (DIV)
    ) u_rx_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (RX),
        .rx_byte    (rx_byte_s),
        .byte_valid (byte_valid_s),
        .frame_err  (frame_err_s)
    );

`ifdef UART_CMD_RX_CHECKSUM_EN
    assign chk_ok_s = (pkt_checksum(opc_q, addr_q, dat_q) == rx_byte_s);
`else
    assign chk_ok_s = 1'b1;
`endif

    assign conf_addr  = conf_addr_q;
    assign conf_data  = conf_data_q;
    assign hdr_en     = hdr_q;
    assign sccb_start = sccb_q;
    assign take_pic   = pic_q;
    assign cmd_err    = err_q;
    assign busy_led   = busy_q;

    // Packet FSM next-state, inter-byte timeout and action decode.
    always_comb begin
        pkt_d       = pkt_q;
        opc_d       = opc_q;
        addr_d      = addr_q;
        dat_d       = dat_q;
        conf_addr_d = conf_addr_q;
        conf_data_d = conf_data_q;
        hdr_d       = hdr_q;
        sccb_d      = 1'b0;
        pic_d       = 1'b0;
        err_d       = 1'b0;

        if ((pkt_q == PKT_WAIT_SYNC) || byte_valid_s) begin
            timer_d = 32'd0;
        end else begin
            timer_d = timer_q + 32'd1;
        end

        if (frame_err_s) begin
            err_d = 1'b1;
            pkt_d = PKT_WAIT_SYNC;
        end else if ((pkt_q != PKT_WAIT_SYNC) && (timer_q == TO_LAST)) begin
            err_d = 1'b1;
            pkt_d = PKT_WAIT_SYNC;
        end else if (byte_valid_s) begin
            case (pkt_q)
                PKT_WAIT_SYNC: begin
                    if (rx_byte_s == SYNC_BYTE) begin
                        pkt_d = PKT_OPC;
                    end else begin
                        pkt_d = PKT_WAIT_SYNC;
                    end
                end
                PKT_OPC: begin
                    opc_d = rx_byte_s;
                    pkt_d = PKT_ADDR;
                end
                PKT_ADDR: begin
                    addr_d = rx_byte_s;
                    pkt_d  = PKT_DATA;
                end
                PKT_DATA: begin
                    dat_d = rx_byte_s;
                    pkt_d = PKT_CHK;
                end
                PKT_CHK: begin
                    pkt_d = PKT_WAIT_SYNC;
                    if (!chk_ok_s) begin
                        err_d = 1'b1;
                    end else begin
                        case (opc_q)
                            OPC_WRITE: begin
                                conf_addr_d = addr_q;
                                conf_data_d = dat_q;
                                sccb_d      = 1'b1;
                            end
                            OPC_PIC: begin
                                pic_d = 1'b1;
                            end
                            OPC_HDR: begin
                                hdr_d = dat_q[0];
                            end
                            default: begin
                                err_d = 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    pkt_d = PKT_WAIT_SYNC;
                end
            endcase
        end else begin
            pkt_d = pkt_q;
        end

        busy_d = (pkt_d != PKT_WAIT_SYNC);
    end

    // Packet FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q       <= PKT_WAIT_SYNC;
            opc_q       <= 8'h00;
            addr_q      <= 8'h00;
            dat_q       <= 8'h00;
            timer_q     <= 32'd0;
            conf_addr_q <= 8'h00;
            conf_data_q <= 8'h00;
            hdr_q       <= 1'b0;
            sccb_q      <= 1'b0;
            pic_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pkt_q       <= pkt_d;
            opc_q       <= opc_d;
            addr_q      <= addr_d;
            dat_q       <= dat_d;
            timer_q     <= timer_d;
            conf_addr_q <= conf_addr_d;
            conf_data_q <= conf_data_d;
            hdr_q       <= hdr_d;
            sccb_q      <= sccb_d;
            pic_q       <= pic_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_rx
// Directed, table-driven bench for uart_cmd_rx. Runs the receiver at a
// small divider (DIV = 2, 32 clk per bit) and a short timeout so complete
// packets and the timeout case fit in a short run.
// -----------------------------------------------------------------------------
module tb_uart_cmd_rx;

    localparam int BIT = 32;
    localparam int TO  = 4000;
`ifdef UART_CMD_RX_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] conf_addr, conf_data;
    logic       sccb_start, take_pic, hdr_en, cmd_err, busy_led;

    uart_cmd_rx #(
        .CLK_HZ      (3200000),
        .BAUD        (100000),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (rx),
        .conf_addr  (conf_addr),
        .conf_data  (conf_data),
        .sccb_start (sccb_start),
        .take_pic   (take_pic),
        .hdr_en     (hdr_en),
        .cmd_err    (cmd_err),
        .busy_led   (busy_led)
    );

    always #5 clk = ~clk;

    // Pulse counters and the address/data seen alongside each sccb_start.
    int         n_sccb = 0, n_pic = 0, n_err = 0;
    logic [7:0] seen_addr = 8'h00, seen_data = 8'h00;
    always @(posedge clk) begin
        if (sccb_start) begin
            n_sccb    <= n_sccb + 1;
            seen_addr <= conf_addr;
            seen_data <= conf_data;
        end
        if (take_pic) n_pic <= n_pic + 1;
        if (cmd_err)  n_err <= n_err + 1;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_pkt(input logic [39:0] p);
        for (int i = 4; i >= 0; i--) begin
            send_byte(p[i*8 +: 8], 1'b1);
        end
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        logic [39:0] pkt;
        int          d_sccb;
        int          d_pic;
        int          d_err;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        hdr;
    } vec_t;

    vec_t vecs[8];
    int   s_sccb, s_pic, s_err;

    initial begin
        vecs[0] = '{40'hA5_01_12_34_27, 1, 0, 0, 8'h12, 8'h34, 1'b0};
        vecs[1] = '{40'hA5_02_00_00_02, 0, 1, 0, 8'h12, 8'h34, 1'b0};
        vecs[2] = '{40'hA5_03_00_01_02, 0, 0, 0, 8'h12, 8'h34, 1'b1};
        vecs[3] = '{40'hA5_01_56_78_00, CHK_EN ? 0 : 1, 0, CHK_EN ? 1 : 0,
                    CHK_EN ? 8'h12 : 8'h56, CHK_EN ? 8'h34 : 8'h78, 1'b1};
        vecs[4] = '{40'hA5_07_00_00_07, 0, 0, 1,
                    CHK_EN ? 8'h12 : 8'h56, CHK_EN ? 8'h34 : 8'h78, 1'b1};
        vecs[5] = '{40'hA5_03_A5_00_A6, 0, 0, 0,
                    CHK_EN ? 8'h12 : 8'h56, CHK_EN ? 8'h34 : 8'h78, 1'b0};
        vecs[6] = '{40'hA5_01_A5_A5_01, 1, 0, 0, 8'hA5, 8'hA5, 1'b0};
        vecs[7] = '{40'hA5_03_00_01_02, 0, 0, 0, 8'hA5, 8'hA5, 1'b1};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_conf_addr", conf_addr, 8'h00);
        check("rst_conf_data", conf_data, 8'h00);
        check("rst_hdr_en", hdr_en, 0);
        check("rst_busy", busy_led, 0);
        check("rst_pulses", {sccb_start, take_pic, cmd_err}, 0);
        rst_n = 1'b1;
        repeat (BIT) @(negedge clk);

        // Table-driven packets
        for (int v = 0; v < 8; v++) begin
            s_sccb = n_sccb; s_pic = n_pic; s_err = n_err;
            send_pkt(vecs[v].pkt);
            check($sformatf("v%0d_sccb", v), n_sccb - s_sccb, vecs[v].d_sccb);
            check($sformatf("v%0d_pic", v), n_pic - s_pic, vecs[v].d_pic);
            check($sformatf("v%0d_err", v), n_err - s_err, vecs[v].d_err);
            check($sformatf("v%0d_addr", v), conf_addr, vecs[v].addr);
            check($sformatf("v%0d_data", v), conf_data, vecs[v].data);
            check($sformatf("v%0d_hdr", v), hdr_en, vecs[v].hdr);
            check($sformatf("v%0d_busy", v), busy_led, 0);
            if (vecs[v].d_sccb != 0) begin
                check($sformatf("v%0d_pulse_addr", v), seen_addr, vecs[v].addr);
                check($sformatf("v%0d_pulse_data", v), seen_data, vecs[v].data);
            end
        end

        // Junk byte before SYNC is ignored silently
        s_pic = n_pic; s_err = n_err;
        send_byte(8'h3C, 1'b1);
        send_pkt(40'hA5_02_00_00_02);
        check("junk_pic", n_pic - s_pic, 1);
        check("junk_err", n_err - s_err, 0);

        // Inter-byte timeout, then recovery
        s_sccb = n_sccb; s_err = n_err;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        check("to_busy_mid", busy_led, 1);
        repeat (TO + 100) @(negedge clk);
        check("to_err", n_err - s_err, 1);
        check("to_busy_after", busy_led, 0);
        check("to_no_sccb", n_sccb - s_sccb, 0);
        send_pkt(40'hA5_01_9A_BC_27);
        check("to_next_sccb", n_sccb - s_sccb, 1);
        check("to_next_addr", conf_addr, 8'h9A);
        check("to_next_data", conf_data, 8'hBC);

        // Framing error inside a packet aborts it
        s_err = n_err; s_pic = n_pic;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (BIT) @(negedge clk);
        check("fe_err", n_err - s_err, 1);
        check("fe_busy", busy_led, 0);
        check("fe_addr_kept", conf_addr, 8'h9A);
        send_pkt(40'hA5_02_00_00_02);
        check("fe_next_pic", n_pic - s_pic, 1);
        check("fe_next_err", n_err - s_err, 1);

        // Short low glitch on an idle line
        s_err = n_err; s_sccb = n_sccb; s_pic = n_pic;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("gl_err", n_err - s_err, 0);
        check("gl_busy", busy_led, 0);
        check("gl_actions", (n_sccb - s_sccb) + (n_pic - s_pic), 0);

        // Reset in the middle of the DATA-field byte
        send_pkt(40'hA5_03_00_01_02);
        check("mr_hdr_before", hdr_en, 1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT + BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_conf_addr", conf_addr, 8'h00);
        check("mr_conf_data", conf_data, 8'h00);
        check("mr_hdr_en", hdr_en, 0);
        check("mr_busy", busy_led, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("mr_busy_idle", busy_led, 0);
        s_sccb = n_sccb; s_err = n_err;
        send_pkt(40'hA5_01_12_34_27);
        check("mr_next_sccb", n_sccb - s_sccb, 1);
        check("mr_next_err", n_err - s_err, 0);
        check("mr_next_addr", conf_addr, 8'h12);
        check("mr_next_data", conf_data, 8'h34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
